snoopy_move_scheduler: RTL and testbench
========================================

SNOOPY_MOVE_SCHEDULER -- requirements
Module: snoopy_move_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 250000, clocks per base tick; SHALL be >= 2.
REQ-002 Parameter SLOW_TICKS, default 4, base ticks between steps before acceleration; SHALL be >= 1.
REQ-003 Parameter FAST_TICKS, default 1, base ticks between steps after acceleration; SHALL be >= 1.
REQ-004 Parameter ACCEL_STEPS, default 8, emitted steps after which the fast period applies; SHALL be >= 1.
REQ-005 clock  in  1  system clock; reset reset, synchronous, active-low; clock clock.
REQ-006 reset  in  1  synchronous active-low reset.
REQ-007 key_left  in  1  raw asynchronous left key level.
REQ-008 key_right  in  1  raw asynchronous right key level.
REQ-009 pause  in  1  synchronous level; suppresses all motion while high.
REQ-010 move_left  out  1  registered one-cycle step pulse to horizontal position FSM left input.
REQ-011 move_right  out  1  registered one-cycle step pulse to horizontal position FSM right input.
REQ-012 fast  out  1  registered; high while in S_LEFT/S_RIGHT with step count >= ACCEL_STEPS.
REQ-013 dir_state  out  2  registered state: 00 idle, 01 left, 10 right, 11 paused.

Function
REQ-014 key_left/key_right SHALL each pass a 2-flop synchronizer (kl_s, kr_s); rising edges are detected against a third registered copy.
REQ-015 States SHALL be S_IDLE, S_LEFT, S_RIGHT, S_PAUSE, encoded as dir_state.
REQ-016 Any state with pause=1 SHALL go to S_PAUSE; S_PAUSE with pause=0 SHALL go to S_IDLE; pause has priority over all other transitions.
REQ-017 S_IDLE: kl_s&!kr_s -> S_LEFT; kr_s&!kl_s -> S_RIGHT; both or neither -> stay.
REQ-018 S_LEFT: !kl_s -> S_RIGHT if kr_s else S_IDLE; kr_s rising edge with kl_s held -> S_RIGHT (last pressed wins); S_RIGHT symmetric.
REQ-019 Entering S_LEFT/S_RIGHT (including a direct swap) SHALL clear the prescaler, tick counter and step counter, and deassert fast.
REQ-020 Entry step: the matching move output SHALL pulse for one cycle in the cycle after the state register first holds the new direction (3 clock edges after the key is first sampled high).
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 and wrap, producing a one-cycle base tick at TICK_DIV-1, only in S_LEFT/S_RIGHT.
REQ-022 Subsequent steps SHALL be spaced pulse-to-pulse by period*TICK_DIV clocks, period = SLOW_TICKS while step count < ACCEL_STEPS, else FAST_TICKS.
REQ-023 Step counter SHALL count emitted pulses including the entry pulse and saturate at ACCEL_STEPS; fast rises with the pulse that reaches ACCEL_STEPS.
REQ-024 move_left and move_right SHALL never be high in the same cycle; consecutive pulses SHALL be separated by >= 1 low cycle.
REQ-025 Leaving a direction state SHALL suppress all further pulses of that direction from the next cycle; a pulse in flight in the exit cycle completes.
REQ-026 No pulses SHALL be emitted in S_IDLE or S_PAUSE.

Reset
REQ-027 reset=0 at a clock edge SHALL force state S_IDLE, synchronizers, counters to 0, and move_left=move_right=fast=0, dir_state=00, from the next cycle, regardless of current state.
REQ-028 After release, behaviour SHALL resume per REQ-017 using fresh synchronizer samples.

Verification (TICK_DIV=4, SLOW_TICKS=3, FAST_TICKS=1, ACCEL_STEPS=2; key sampled high at edge 0)
REQ-029 Hold key_left -> move_left pulses at cycles 3, 15, 19, 23, ...; fast=1 from cycle 15; dir_state=01; move_right always 0.
REQ-030 key_left and key_right rise same edge -> dir_state stays 00, no pulses.
REQ-031 Hold left to cycle 20, raise key_right at edge 20 -> move_right at 23, next at 35; fast=0 from 23 until 35; no move_left after 23.
REQ-032 Hold left, pause=1 at cycle 16 -> dir_state=11, no pulses while paused; pause=0 -> 00 then 01, entry pulse, slow period restarts, fast=0.
REQ-033 reset=0 at cycle 17 during fast left hold -> all outputs 0 at cycle 18; after release with key held, entry pulse 3 edges after first synchronized sample.
REQ-034 key_left high for one clock only -> exactly one move_left pulse, then dir_state returns 00.

Source files
------------

// File: rtl/snoopy_move_scheduler.sv
// Turns synchronized left/right key levels into spaced one-cycle step pulses
// for the horizontal position FSM, with a slow-then-fast repeat rate.
module snoopy_move_scheduler #(
  parameter int TICK_DIV    = 250000,
  parameter int SLOW_TICKS  = 4,
  parameter int FAST_TICKS  = 1,
  parameter int ACCEL_STEPS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       pause,
  output logic       move_left,
  output logic       move_right,
  output logic       fast,
  output logic [1:0] dir_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(SLOW_TICKS + FAST_TICKS + 1);
  localparam int SW = $clog2(ACCEL_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LEFT  = 2'b01,
    S_RIGHT = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          kl_meta_q, kl_meta_d, kr_meta_q, kr_meta_d;
  logic          kl_s_q, kl_s_d, kr_s_q, kr_s_d;
  logic          kl_last_q, kl_last_d, kr_last_q, kr_last_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic          pending_q, pending_d;
  logic          move_left_q, move_left_d, move_right_q, move_right_d;
  logic          fast_q, fast_d;

  logic          kl_rise_s, kr_rise_s, in_dir_s, enter_s, fire_s;
  int            period_s;

  // State and datapath register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      kl_meta_q    <= 1'b0;
      kr_meta_q    <= 1'b0;
      kl_s_q       <= 1'b0;
      kr_s_q       <= 1'b0;
      kl_last_q    <= 1'b0;
      kr_last_q    <= 1'b0;
      presc_q      <= '0;
      tick_cnt_q   <= '0;
      step_q       <= '0;
      pending_q    <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fast_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kl_meta_q    <= kl_meta_d;
      kr_meta_q    <= kr_meta_d;
      kl_s_q       <= kl_s_d;
      kr_s_q       <= kr_s_d;
      kl_last_q    <= kl_last_d;
      kr_last_q    <= kr_last_d;
      presc_q      <= presc_d;
      tick_cnt_q   <= tick_cnt_d;
      step_q       <= step_d;
      pending_q    <= pending_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      fast_q       <= fast_d;
    end
  end

  // Key synchronizers and direction FSM; pause overrides every transition.
  always_comb begin
    kl_meta_d = key_left;
    kr_meta_d = key_right;
    kl_s_d    = kl_meta_q;
    kr_s_d    = kr_meta_q;
    kl_last_d = kl_s_q;
    kr_last_d = kr_s_q;
    kl_rise_s = kl_s_q & ~kl_last_q;
    kr_rise_s = kr_s_q & ~kr_last_q;
    state_d   = state_q;
    if (pause) begin
      state_d = S_PAUSE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (kl_s_q && !kr_s_q)      state_d = S_LEFT;
          else if (kr_s_q && !kl_s_q) state_d = S_RIGHT;
          else                        state_d = S_IDLE;
        end
        S_LEFT: begin
          if (!kl_s_q)        state_d = kr_s_q ? S_RIGHT : S_IDLE;
          else if (kr_rise_s) state_d = S_RIGHT;
          else                state_d = S_LEFT;
        end
        S_RIGHT: begin
          if (!kr_s_q)        state_d = kl_s_q ? S_LEFT : S_IDLE;
          else if (kl_rise_s) state_d = S_LEFT;
          else                state_d = S_RIGHT;
        end
        S_PAUSE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Step timing: an entry step waits until no pulse is on the outputs, then
  // the prescaler starts; a step issued in the exit cycle is still delivered.
  always_comb begin
    in_dir_s   = (state_q == S_LEFT) || (state_q == S_RIGHT);
    enter_s    = ((state_d == S_LEFT) || (state_d == S_RIGHT)) && (state_d != state_q);
    period_s   = (int'(step_q) >= ACCEL_STEPS) ? FAST_TICKS : SLOW_TICKS;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    step_d     = step_q;
    pending_d  = pending_q;
    fire_s     = 1'b0;
    if (in_dir_s) begin
      if (pending_q) begin
        if (!move_left_q && !move_right_q) begin
          fire_s    = 1'b1;
          pending_d = 1'b0;
        end else begin
          fire_s    = 1'b0;
        end
      end else if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (int'(tick_cnt_q) + 1 >= period_s) begin
          fire_s     = 1'b1;
          tick_cnt_d = '0;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end
    if (fire_s && (int'(step_q) < ACCEL_STEPS)) begin
      step_d = step_q + 1'b1;
    end else begin
      step_d = step_q;
    end
    if (enter_s) begin
      presc_d    = '0;
      tick_cnt_d = '0;
      step_d     = '0;
      pending_d  = 1'b1;
    end else begin
      pending_d  = pending_d;
    end
    move_left_d  = fire_s && (state_q == S_LEFT);
    move_right_d = fire_s && (state_q == S_RIGHT);
    fast_d       = ((state_d == S_LEFT) || (state_d == S_RIGHT)) && !enter_s &&
                   (int'(step_d) >= ACCEL_STEPS);
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fast       = fast_q;
  assign dir_state  = state_q;

endmodule

// File: tb/tb_snoopy_move_scheduler.sv
// Scoreboard bench: scenarios queue expected pulses and state samples with
// absolute cycle numbers; a negedge monitor pops and compares them.
module tb_snoopy_move_scheduler;

  localparam int TICK_DIV = 4, SLOW_TICKS = 3, FAST_TICKS = 1, ACCEL_STEPS = 2;
  localparam logic [1:0] D_IDLE = 2'b00, D_LEFT = 2'b01, D_RIGHT = 2'b10, D_PAUSE = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, pause = 1'b0;
  logic       move_left, move_right, fast;
  logic [1:0] dir_state;

  snoopy_move_scheduler #(
    .TICK_DIV(TICK_DIV), .SLOW_TICKS(SLOW_TICKS),
    .FAST_TICKS(FAST_TICKS), .ACCEL_STEPS(ACCEL_STEPS)
  ) dut (
    .clock(clock), .reset(reset), .key_left(key_left), .key_right(key_right),
    .pause(pause), .move_left(move_left), .move_right(move_right),
    .fast(fast), .dir_state(dir_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int c; int right; int f; } pulse_t;
  typedef struct { int c; int dir; int f; } samp_t;
  pulse_t pq[$];
  samp_t  sq[$];
  pulse_t p;
  samp_t  s;
  int checks = 0;
  int passes = 0;
  int base = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic ep(int c, int right, int f);
    pulse_t t;
    t.c = base + c; t.right = right; t.f = f;
    pq.push_back(t);
  endtask

  task automatic es(int c, logic [1:0] d, int f);
    samp_t t;
    t.c = base + c; t.dir = int'(d); t.f = f;
    sq.push_back(t);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic drain(string name);
    check({name, "_pulses_left"}, pq.size(), 0);
    check({name, "_samples_left"}, sq.size(), 0);
    pq.delete();
    sq.delete();
  endtask

  // Monitor: every pulse must match the next queued one; samples at their cycle.
  always @(negedge clock) begin
    if (move_left === 1'b1 || move_right === 1'b1) begin
      check("pulse_exclusive", int'(move_left & move_right), 0);
      if (pq.size() == 0) begin
        check("unexpected_pulse_cycle", cyc, -1);
      end else begin
        p = pq.pop_front();
        check("pulse_cycle", cyc, p.c);
        check("pulse_dir_right", int'(move_right), p.right);
        check("pulse_fast", int'(fast), p.f);
      end
    end
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      s = sq.pop_front();
      check("sample_cycle", cyc, s.c);
      check("dir_state", int'(dir_state), s.dir);
      check("fast", int'(fast), s.f);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    // Reset state, from any prior state
    reset = 1'b0;
    base = cyc;
    es(1, D_IDLE, 0);
    es(2, D_IDLE, 0);
    wait_cyc(base + 3);
    reset = 1'b1;
    wait_cyc(base + 5);
    drain("reset");

    // Hold left: entry at 3, slow gap 12, then fast gap 4
    base = cyc + 1;
    key_left = 1'b1;
    ep(3, 0, 0); ep(15, 0, 1); ep(19, 0, 1); ep(23, 0, 1);
    es(2, D_LEFT, 0); es(14, D_LEFT, 0); es(15, D_LEFT, 1); es(26, D_IDLE, 0);
    wait_cyc(base + 23);
    key_left = 1'b0;
    wait_cyc(base + 40);
    drain("hold_left");

    // Both keys on the same edge: stay idle
    base = cyc + 1;
    key_left = 1'b1; key_right = 1'b1;
    es(3, D_IDLE, 0); es(10, D_IDLE, 0);
    wait_cyc(base + 12);
    key_left = 1'b0; key_right = 1'b0;
    wait_cyc(base + 20);
    drain("both_keys");

    // Left held, right pressed at edge 20: last pressed wins
    base = cyc + 1;
    key_left = 1'b1;
    ep(3, 0, 0); ep(15, 0, 1); ep(19, 0, 1); ep(23, 1, 0); ep(35, 1, 1);
    es(21, D_LEFT, 1); es(22, D_RIGHT, 0); es(23, D_RIGHT, 0);
    es(34, D_RIGHT, 0); es(35, D_RIGHT, 1); es(38, D_IDLE, 0);
    wait_cyc(base + 19);
    key_right = 1'b1;
    wait_cyc(base + 35);
    key_left = 1'b0; key_right = 1'b0;
    wait_cyc(base + 45);
    drain("swap");

    // Pause during fast hold, then resume with a fresh slow period
    base = cyc + 1;
    key_left = 1'b1;
    ep(3, 0, 0); ep(15, 0, 1); ep(32, 0, 0); ep(44, 0, 1);
    es(15, D_LEFT, 1); es(16, D_PAUSE, 0); es(29, D_PAUSE, 0); es(30, D_IDLE, 0);
    es(31, D_LEFT, 0); es(43, D_LEFT, 0); es(44, D_LEFT, 1);
    wait_cyc(base + 15);
    pause = 1'b1;
    wait_cyc(base + 29);
    pause = 1'b0;
    wait_cyc(base + 44);
    key_left = 1'b0;
    wait_cyc(base + 55);
    drain("pause");

    // Reset during fast hold with the key still down
    base = cyc + 1;
    key_left = 1'b1;
    ep(3, 0, 0); ep(15, 0, 1); ep(23, 0, 0);
    es(17, D_LEFT, 1); es(18, D_IDLE, 0); es(19, D_IDLE, 0); es(22, D_LEFT, 0);
    wait_cyc(base + 17);
    reset = 1'b0;
    wait_cyc(base + 19);
    reset = 1'b1;
    wait_cyc(base + 24);
    key_left = 1'b0;
    wait_cyc(base + 35);
    drain("reset_hold");

    // One-clock key press: exactly one pulse
    base = cyc + 1;
    key_left = 1'b1;
    ep(3, 0, 0);
    es(2, D_LEFT, 0); es(3, D_IDLE, 0); es(8, D_IDLE, 0);
    @(negedge clock);
    key_left = 1'b0;
    wait_cyc(base + 14);
    drain("blip");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
